// File: rtl/avmm_ram_pkg.sv
// Shared types and constants for the pipelined Avalon-MM on-chip RAM.
package avmm_ram_pkg;

    localparam int BYTE_W  = 8;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 2;

    // CLEAR: post-reset fill in progress; READY: serving bus transfers.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

endpackage

// File: rtl/avmm_ram_core.sv
// Single-port byte-enabled RAM, write-first, with a registered read output.
// The storage array is never reset; only the output register is.
module avmm_ram_core
    import avmm_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W/BYTE_W-1:0] be,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] merged;

    // Word as it looks after this cycle's byte-lane write (write-first view).
    always_comb begin
        merged = mem[addr];
        for (int i = 0; i < NB; i++) begin
            if (be[i]) merged[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
        end
    end

    // Byte-lane writes into the array; disabled lanes keep their contents.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Registered read port; a write returns the freshly written word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= we ? merged : mem[addr];
        end
    end

endmodule

// File: rtl/avmm_onchip_ram_pipelined.sv
// Avalon-MM slave on-chip RAM with a post-reset clear sequence and a
// 1- or 2-stage read pipeline. clken = 0 freezes every register.
// Handshake: a transfer is accepted on a clken cycle in READY with
// chipselect and (read | write) high; waitrequest is high whenever no
// transfer can be accepted. Each accepted read returns exactly one
// readdatavalid pulse, in issue order; read+write together is a write only.
module avmm_onchip_ram_pipelined
    import avmm_ram_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 2,
    parameter int                READ_LATENCY   = 1,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W/BYTE_W-1:0] byteenable,
    input  logic                     chipselect,
    input  logic                     read,
    input  logic                     write,
    input  logic [DATA_W-1:0]        writedata,
    input  logic                     clken,
    output logic                     waitrequest,
    output logic [DATA_W-1:0]        readdata,
    output logic                     readdatavalid,
    output logic                     init_busy
);

    localparam int                NB          = DATA_W / BYTE_W;
    localparam int                DEPTH       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam ram_state_e        RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

    if (DATA_W % BYTE_W != 0) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8");
    end
    if (READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end

    ram_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clear_cnt_q;
    logic              rd_accept;
    logic              rd_valid_q;

    logic              core_en, core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [NB-1:0]     core_be;
    logic [DATA_W-1:0] core_wdata, core_rdata;

    // State register and clear counter; both freeze while clken is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= RESET_STATE;
            clear_cnt_q <= '0;
        end else if (clken) begin
            state_q <= state_d;
            if (state_q == CLEAR) clear_cnt_q <= clear_cnt_q + ADDR_W'(1);
        end
    end

    // Next state, accept decode and steering of the RAM port (clear vs bus).
    always_comb begin
        state_d     = state_q;
        waitrequest = 1'b1;
        init_busy   = 1'b0;
        rd_accept   = 1'b0;
        core_en     = 1'b0;
        core_we     = 1'b0;
        core_addr   = address;
        core_be     = byteenable;
        core_wdata  = writedata;
        case (state_q)
            CLEAR: begin
                init_busy  = 1'b1;
                core_en    = reset_n & clken;
                core_we    = 1'b1;
                core_addr  = clear_cnt_q;
                core_be    = '1;
                core_wdata = CLEAR_VALUE;
                if (clear_cnt_q == LAST_ADDR) state_d = READY;
            end
            READY: begin
                waitrequest = ~clken;
                core_en     = reset_n & clken & chipselect & (read | write);
                core_we     = write;
                rd_accept   = clken & chipselect & read & ~write;
            end
            default: state_d = RESET_STATE;
        endcase
    end

    avmm_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (core_en),
        .we      (core_we),
        .addr    (core_addr),
        .be      (core_be),
        .wdata   (core_wdata),
        .rdata   (core_rdata)
    );

    // First valid stage, aligned with the RAM output register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
        end else if (clken) begin
            rd_valid_q <= rd_accept;
        end
    end

    // The valid is only presented on enabled cycles so a stalled return
    // shows up exactly once, on the cycle that also retires it.
    if (READ_LATENCY == 2) begin : g_lat2
        logic              valid2_q;
        logic [DATA_W-1:0] data2_q;

        // Extra output stage for the 2-cycle latency option.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                valid2_q <= 1'b0;
                data2_q  <= '0;
            end else if (clken) begin
                valid2_q <= rd_valid_q;
                data2_q  <= core_rdata;
            end
        end

        assign readdatavalid = valid2_q & clken;
        assign readdata      = data2_q;
    end else begin : g_lat1
        assign readdatavalid = rd_valid_q & clken;
        assign readdata      = core_rdata;
    end

endmodule

// File: tb/tb_avmm_onchip_ram_pipelined.sv
// Bench for the pipelined on-chip RAM: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_avmm_onchip_ram_pipelined;

    localparam int          DW    = 32;
    localparam int          AW    = 3;
    localparam int          NB    = DW / 8;
    localparam int          DEPTH = 2 ** AW;
    localparam int          LAT   = 2;
    localparam logic [31:0] CV    = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] address;
    logic [NB-1:0] byteenable;
    logic          chipselect, read, write, clken;
    logic [DW-1:0] writedata;
    logic          waitrequest, readdatavalid, init_busy;
    logic [DW-1:0] readdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    avmm_onchip_ram_pipelined #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .READ_LATENCY   (LAT),
        .CLEAR_ON_RESET (1'b1),
        .CLEAR_VALUE    (CV)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .byteenable    (byteenable),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .clken         (clken),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .init_busy     (init_busy)
    );

    // clock
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endfunction

    // reference model: memory image, words left to clear, pending reads
    logic [DW-1:0] mem_m [DEPTH];
    int            clear_left = 0;
    logic [DW-1:0] pend_d[$];
    int            pend_a[$];
    bit            mdl_ok = 1'b0;
    logic [DW-1:0] obs_d[$];
    int            obs_t[$];

    always @(posedge clk) begin
        cyc_n++;
        if (!reset_n) begin
            clear_left = DEPTH;
            pend_d.delete();
            pend_a.delete();
            mdl_ok = 1'b1;
        end else if (clken) begin
            if (pend_a.size() > 0 && pend_a[0] == LAT) begin
                void'(pend_a.pop_front());
                void'(pend_d.pop_front());
            end
            foreach (pend_a[i]) pend_a[i]++;
            if (clear_left > 0) begin
                mem_m[DEPTH - clear_left] = CV;
                clear_left--;
            end else if (chipselect && (read || write)) begin
                if (write) begin
                    for (int b = 0; b < NB; b++)
                        if (byteenable[b]) mem_m[address][b*8 +: 8] = writedata[b*8 +: 8];
                end else begin
                    pend_d.push_back(mem_m[address]);
                    pend_a.push_back(1);
                end
            end
        end
    end

    // compare process: every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (mdl_ok) begin
            logic exp_valid;
            exp_valid = clken && pend_a.size() > 0 && pend_a[0] == LAT;
            chk("waitrequest", waitrequest, (clear_left > 0) || !clken);
            chk("init_busy", init_busy, clear_left > 0);
            chk("readdatavalid", readdatavalid, exp_valid);
            if (exp_valid) chk("readdata", readdata, pend_d[0]);
            if (readdatavalid === 1'b1) begin
                obs_d.push_back(readdata);
                obs_t.push_back(cyc_n);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; byteenable = '0; writedata = '0;
    endtask

    task automatic cyc(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [NB-1:0] be, input logic [DW-1:0] d);
        chipselect = cs; read = rd; write = wr; address = a; byteenable = be; writedata = d;
        tick();
        idle();
    endtask

    task automatic chk_rd(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        obs_d.delete();
        obs_t.delete();
        cyc(1'b1, 1'b1, 1'b0, a, '0, '0);
        for (int i = 0; i < 10; i++) begin
            if (obs_d.size() > 0) break;
            tick();
        end
        chk({nm, "_returned"}, DW'(obs_d.size()), 1);
        if (obs_d.size() > 0) chk(nm, obs_d[0], exp);
    endtask

    task automatic count_clear(input string nm);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (init_busy) n++;
            else break;
        end
        chk(nm, DW'(n), DEPTH);
    endtask

    // stimulus
    initial begin
        int a0;
        reset_n = 1'b0;
        clken   = 1'b1;
        idle();
        repeat (3) tick();
        @(negedge clk);
        chk("rst_waitrequest", waitrequest, 1);
        chk("rst_readdatavalid", readdatavalid, 0);
        chk("rst_readdata", readdata, 0);
        chk("rst_init_busy", init_busy, 1);
        tick();
        reset_n = 1'b1;
        count_clear("clear_cycles");
        for (int i = 0; i < DEPTH; i++) chk_rd("cleared_word", AW'(i), 32'hDEAD_BEEF);

        // byte-lane write over a zeroed word, then an all-lanes-off write
        cyc(1'b1, 1'b0, 1'b1, 3'd1, 4'hF, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 3'd1, 4'b0101, 32'h1122_3344);
        chk_rd("be_write", 3'd1, 32'h0022_0044);
        cyc(1'b1, 1'b0, 1'b1, 3'd1, 4'b0000, 32'hFFFF_FFFF);
        chk_rd("be_zero", 3'd1, 32'h0022_0044);

        // read immediately after write
        cyc(1'b1, 1'b0, 1'b1, 3'd5, 4'hF, 32'hCAFE_0005);
        chk_rd("read_after_write", 3'd5, 32'hCAFE_0005);

        // back-to-back reads
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, AW'(i), 4'hF, 32'(10 + i));
        obs_d.delete();
        obs_t.delete();
        cyc(1'b1, 1'b1, 1'b0, 3'd0, '0, '0);
        a0 = cyc_n;
        for (int i = 1; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, AW'(i), '0, '0);
        repeat (6) tick();
        chk("b2b_count", DW'(obs_d.size()), 4);
        for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
            chk("b2b_data", obs_d[i], 32'(10 + i));
            chk("b2b_cycle", DW'(obs_t[i]), DW'(a0 + 1 + i));
        end

        // stall with a read in flight
        obs_d.delete();
        obs_t.delete();
        cyc(1'b1, 1'b1, 1'b0, 3'd2, '0, '0);
        clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_waitrequest", waitrequest, 1);
            chk("stall_valid", readdatavalid, 0);
            tick();
        end
        clken = 1'b1;
        repeat (5) tick();
        chk("stall_count", DW'(obs_d.size()), 1);
        if (obs_d.size() > 0) chk("stall_data", obs_d[0], 32'd12);

        // read and write together: write wins, no return
        obs_d.delete();
        cyc(1'b1, 1'b1, 1'b1, 3'd2, 4'hF, 32'hA5A5_A5A5);
        repeat (5) tick();
        chk("rw_no_valid", DW'(obs_d.size()), 0);
        chk_rd("rw_read", 3'd2, 32'hA5A5_A5A5);

        // reset with a read in flight: nothing comes back
        obs_d.delete();
        cyc(1'b1, 1'b1, 1'b0, 3'd3, '0, '0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        count_clear("clear_after_flush");
        repeat (4) tick();
        chk("flushed_read", DW'(obs_d.size()), 0);

        // randomized traffic with stalls and occasional resets
        for (int i = 0; i < 700; i++) begin
            clken   = ($urandom_range(0, 7) != 0);
            reset_n = ($urandom_range(0, 150) != 0);
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 2) == 0), AW'($urandom_range(0, DEPTH - 1)),
                NB'($urandom_range(0, 15)), DW'($urandom));
        end
        reset_n = 1'b1;
        clken   = 1'b1;
        repeat (20) tick();

        // reset pulled low at clear cycle 2 restarts the sequence
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        count_clear("clear_restart");
        for (int i = 0; i < DEPTH; i++) chk_rd("restart_word", AW'(i), 32'hDEAD_BEEF);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avmm_onchip_ram_pipelined.md
Name: avmm_onchip_ram_pipelined

Overview:
- Parametrised Avalon-MM slave on-chip RAM; next generation of the SoC's fixed 4x32 single-port on-chip memory.
- Adds configurable width and depth, a pipelined read path with readdatavalid, selectable read latency and a post-reset hardware clear sequence.
- Sits on the Platform Designer interconnect as a scratch/register RAM for the Nios II.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 2, word-address width; DEPTH = 2**ADDR_W.
- READ_LATENCY, 1, cycles from read accept to readdatavalid; legal values are 1 or 2.
- CLEAR_ON_RESET, 1, when 1, all words are written with CLEAR_VALUE after reset.
- CLEAR_VALUE, 0, DATA_W-bit fill pattern used by the clear sequence.

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  synchronous, active-low reset.
- address  in  ADDR_W  word address.
- byteenable  in  DATA_W/8  byte lane enables for writes.
- chipselect  in  1  slave select.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  DATA_W  write data.
- clken  in  1  clock enable; 0 stalls the whole block.
- waitrequest  out  1  1 = transfer not accepted this cycle.
- readdata  out  DATA_W  read data; meaningful only while readdatavalid = 1.
- readdatavalid  out  1  one-cycle pulse per accepted read.
- init_busy  out  1  clear sequence in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (reset_n), sampled on the rising edge of clk.
- Reset values:
  - waitrequest = 1, readdatavalid = 0, readdata = 0, all valid pipe stages = 0, clear counter = 0.
  - init_busy = CLEAR_ON_RESET.
  - RAM contents are not reset by reset_n; only the clear sequence modifies them.
- FSM states: CLEAR, READY.
  - Reset enters CLEAR if CLEAR_ON_RESET = 1, otherwise READY.
  - CLEAR: each cycle with clken = 1, writes CLEAR_VALUE (all byte lanes) to the address in clear_cnt, then increments clear_cnt. After writing DEPTH-1, goes to READY. The full clear takes exactly DEPTH enabled cycles.
  - CLEAR holds waitrequest = 1 and init_busy = 1.
  - READY: waitrequest = ~clken and init_busy = 0.
- Accept conditions:
  - Accept = READY & clken & chipselect & (read | write).
  - Write accept: lanes with byteenable[i] = 1 update byte i at the clock edge; other lanes are unchanged. A write with byteenable = 0 is accepted but changes nothing.
  - read and write asserted together: the write is performed, the read is dropped, and no readdatavalid is produced.
- Read pipeline:
  - READ_LATENCY = 1: RAM output is registered once. readdatavalid is asserted the cycle after accept.
  - READ_LATENCY = 2: an extra output register is added. readdatavalid is asserted 2 cycles after accept.
  - Back-to-back reads are accepted every cycle (throughput 1 per clk). Return order equals issue order.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. The RAM core is write-first on the same port.
- clken = 0:
  - No RAM access, no new accepts.
  - All pipeline and valid registers hold their values. A pending readdatavalid is neither lost nor duplicated; it is emitted once clken returns.
  - The clear counter freezes.
- Reset mid-clear: the clear sequence restarts from address 0.
- Reset with reads in flight: the in-flight reads are discarded and no readdatavalid is emitted for them.
- Address wrap: clear_cnt is ADDR_W bits wide; the terminal condition is clear_cnt == DEPTH-1. There is no overflow state.
- Elaboration checks: DATA_W % 8 != 0 or READ_LATENCY not in {1, 2} is an elaboration-time error.

Decomposition:
- Package avmm_ram_pkg:
  - State enum ram_state_e {CLEAR, READY}.
  - Constant BYTE_W = 8.
  - Legal latency constants LAT_MIN = 1 and LAT_MAX = 2.
- One sub-module, avmm_ram_core: an inferred single-port byte-enabled RAM (write-first, registered output).
- Top level holds the FSM, the clear counter, the accept logic and the latency/valid pipeline.

Test Plan:
- Reset (DATA_W = 32, ADDR_W = 2, CLEAR_VALUE = 32'hDEAD_BEEF) -> waitrequest and init_busy high for exactly 4 cycles, then low; reads of addresses 0–3 all return 32'hDEAD_BEEF.
- Write 32'h1122_3344 to address 1 with byteenable 4'b0101 over cleared 0 -> a later read of address 1 returns 32'h0022_0044.
- READ_LATENCY = 2: back-to-back reads of addresses 0, 1, 2, 3 (data 10, 11, 12, 13) -> readdatavalid high on 4 consecutive cycles starting 2 cycles after the first accept, data 10, 11, 12, 13 in order.
- Read issued, then clken = 0 for 3 cycles -> readdatavalid is deferred until clken = 1 and pulses exactly once with correct data; waitrequest is high during the stall.
- read and write together at address 2 with data 32'hA5A5_A5A5 -> no readdatavalid; a subsequent read of address 2 returns 32'hA5A5_A5A5.
- reset_n pulled low at clear cycle 2 with ADDR_W = 3 -> clear restarts from address 0 and init_busy stays high for 8 cycles after reset is released.
